card_demux: RTL and testbench

// - Inverse of the card merge stage: takes one 64-bit AXI-Stream whose low TAG_W bits carry a channel index.
// - Dispatches each word to one of NUM_CH per-channel output streams, each with its own FIFO.
// - Sits on the return path of the card kernel, so results fan back out to the per-lane consumers.

---
 rtl/card_demux_if.sv | 25 ++
 rtl/card_demux.sv | 107 ++++++++++
 tb/tb_card_demux.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_demux_if.sv
// rtl/card_demux_if.sv - input stream and per-channel output streams of the card demultiplexer
`timescale 1ns/1ps
interface card_demux_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0]        s_tdata;
    logic                     s_tvalid;
    logic                     s_tready;
    logic [NUM_CH*DATA_W-1:0] m_tdata;
    logic [NUM_CH-1:0]        m_tvalid;
    logic [NUM_CH-1:0]        m_tready;

    // Producer of the tagged stream and consumer of the per-channel streams
    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid
    );

    // The demultiplexer itself
    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid
    );
endinterface

// File: rtl/card_demux.sv
// rtl/card_demux.sv - tag-indexed fan-out of one stream into per-channel FIFOs
`timescale 1ns/1ps
module card_demux #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int STRIP_TAG  = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    card_demux_if.slave st,
    output logic [15:0] err_cnt
);
    localparam int TAG_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DATA_W-1:0] TAG_MASK = {{(DATA_W-TAG_W){1'b0}}, {TAG_W{1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MASK = (STRIP_TAG != 0) ? ~TAG_MASK : {DATA_W{1'b1}};

    logic              stage_v;
    logic [DATA_W-1:0] stage_d;
    logic [TAG_W-1:0]  tag;
    logic              tag_ok;
    logic              drop;
    logic              push_ok;
    logic              accept;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] full;

    logic [CNT_W-1:0]  count  [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];

    assign tag     = stage_d[TAG_W-1:0];
    assign tag_ok  = (int'(tag) < NUM_CH);
    assign drop    = stage_v && !tag_ok;
    // A dropped word frees the stage just like a successful push
    assign push_ok = (|push) || drop;
    // Ready only looks at registered state, so consumer ready never reaches the producer combinationally
    assign st.s_tready = aresetn && (!stage_v || push_ok);
    assign accept  = st.s_tvalid && st.s_tready;

    // Per-channel push/pop decode and output presentation from the FIFO heads
    always_comb begin
        push        = '0;
        pop         = '0;
        full        = '0;
        st.m_tvalid = '0;
        st.m_tdata  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]        = (count[i] == CNT_W'(FIFO_DEPTH));
            push[i]        = stage_v && tag_ok && (tag == TAG_W'(i)) && !full[i];
            st.m_tvalid[i] = (count[i] != '0);
            pop[i]         = (count[i] != '0) && st.m_tready[i];
            st.m_tdata[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]] & OUT_MASK;
        end
    end

    // Single-entry stage: refills on accept, empties once its word is dispatched or dropped
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stage_v <= 1'b0;
            stage_d <= '0;
        end else if (accept) begin
            stage_v <= 1'b1;
            stage_d <= st.s_tdata;
        end else if (push_ok) begin
            stage_v <= 1'b0;
        end
    end

    // FIFO occupancy and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + {{(CNT_W-1){1'b0}}, push[i]}
                                     - {{(CNT_W-1){1'b0}}, pop[i]};
            end
        end
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= stage_d;
        end
    end

    // Saturating count of words whose tag names no channel
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt <= '0;
        end else if (drop && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_card_demux.sv
// tb/tb_card_demux.sv - randomized self-checking bench for card_demux
`timescale 1ns/1ps
module tb_card_demux;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    card_demux_if #(.NUM_CH(8), .DATA_W(64)) if8 ();
    card_demux_if #(.NUM_CH(6), .DATA_W(64)) if6 ();
    logic [15:0] err8;
    logic [15:0] err6;

    card_demux #(.NUM_CH(8), .DATA_W(64), .FIFO_DEPTH(4), .STRIP_TAG(1)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .st(if8.slave), .err_cnt(err8));
    card_demux #(.NUM_CH(6), .DATA_W(64), .FIFO_DEPTH(4), .STRIP_TAG(1)) dut6 (
        .aclk(aclk), .aresetn(aresetn), .st(if6.slave), .err_cnt(err6));

    int checks = 0;
    int errors = 0;

    logic [63:0] exp8 [8][$];
    logic [63:0] got8 [8][$];
    logic [63:0] exp6 [6][$];
    logic [63:0] got6 [6][$];
    int          drop6 = 0;

    logic [7:0]  mask8 = 8'hFF;
    bit          rand8 = 1'b0;
    int          stab_err = 0;
    logic [7:0]  pv8 = '0;
    logic [7:0]  pr8 = '0;
    logic [63:0] pd8 [8];

    // Consumer side: drive ready, log every word that will pop at the next edge, watch stability
    always @(negedge aclk) begin
        logic [7:0] r;
        r = 8'($urandom);
        if8.m_tready = rand8 ? r : mask8;
        if6.m_tready = '1;
        if (!aresetn) begin
            pv8 = '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pv8[i] && !pr8[i] &&
                    (!if8.m_tvalid[i] || if8.m_tdata[i*64 +: 64] !== pd8[i]))
                    stab_err++;
                if (if8.m_tvalid[i] && if8.m_tready[i])
                    got8[i].push_back(if8.m_tdata[i*64 +: 64]);
                pv8[i] = if8.m_tvalid[i];
                pr8[i] = if8.m_tready[i];
                pd8[i] = if8.m_tdata[i*64 +: 64];
            end
            for (int i = 0; i < 6; i++) begin
                if (if6.m_tvalid[i])
                    got6[i].push_back(if6.m_tdata[i*64 +: 64]);
            end
        end
    end

    task automatic clear_model();
        for (int c = 0; c < 8; c++) begin exp8[c].delete(); got8[c].delete(); end
        for (int c = 0; c < 6; c++) begin exp6[c].delete(); got6[c].delete(); end
    endtask

    // Offer one word, wait for acceptance, record what the channel should later see
    task automatic send(input bit six, input logic [63:0] d);
        int n;
        logic [2:0] t;
        t = d[2:0];
        n = 0;
        if (six) begin if6.s_tdata = d; if6.s_tvalid = 1'b1; end
        else     begin if8.s_tdata = d; if8.s_tvalid = 1'b1; end
        while (!(six ? if6.s_tready : if8.s_tready) && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_tready stayed 0 for %0d cycles, required 1", n);
        end else begin
            @(posedge aclk);
            if (six) begin
                if (int'(t) < 6) exp6[t].push_back(d & ~64'h7);
                else             drop6++;
            end else begin
                exp8[t].push_back(d & ~64'h7);
            end
        end
        @(negedge aclk);
        if (six) if6.s_tvalid = 1'b0;
        else     if8.s_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        mask8 = 8'hFF;
        rand8 = 1'b0;
        repeat (4) @(negedge aclk);
        while ((if8.m_tvalid != '0 || if6.m_tvalid != '0) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: m_tvalid8=%h m_tvalid6=%h, required 0", if8.m_tvalid, if6.m_tvalid);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if (if8.s_tready !== 1'b0) begin
            errors++; $display("FAIL reset_s_tready_low: got %b, required 0", if8.s_tready);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (if8.s_tready !== 1'b1) begin
            errors++; $display("FAIL release_s_tready: got %b, required 1", if8.s_tready);
        end
        checks++;
        if (if8.m_tvalid !== 8'h00) begin
            errors++; $display("FAIL reset_m_tvalid: got %h, required 00", if8.m_tvalid);
        end
        checks++;
        if (err8 !== 16'h0 || err6 !== 16'h0) begin
            errors++; $display("FAIL reset_err_cnt: got %h/%h, required 0000/0000", err8, err6);
        end
        @(negedge aclk);
    endtask

    task automatic test_single();
        clear_model();
        send(1'b0, 64'hAAAA_0000_0000_1235);
        checks++;
        if (if8.m_tvalid !== 8'h00) begin
            errors++; $display("FAIL single_early: m_tvalid=%h one edge after accept, required 00", if8.m_tvalid);
        end
        @(negedge aclk);
        checks++;
        if (if8.m_tvalid !== 8'h20) begin
            errors++; $display("FAIL single_valid: m_tvalid=%h, required 20", if8.m_tvalid);
        end
        checks++;
        if (if8.m_tdata[5*64 +: 64] !== 64'hAAAA_0000_0000_1230) begin
            errors++; $display("FAIL single_data: got %h, required aaaa000000001230", if8.m_tdata[5*64 +: 64]);
        end
        wait_idle();
        checks++;
        if (got8[5].size() !== 1) begin
            errors++; $display("FAIL single_count: got %0d words on ch5, required 1", got8[5].size());
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] w [6];
        int acc;
        int cyc;
        clear_model();
        for (int k = 0; k < 6; k++) w[k] = ({$urandom, $urandom} & ~64'h7) | 64'h2;
        mask8 = 8'hFB;
        @(negedge aclk);
        acc = 0;
        for (cyc = 0; cyc < 12; cyc++) begin
            if8.s_tdata = w[acc]; if8.s_tvalid = 1'b1;
            if (if8.s_tready) begin
                @(posedge aclk);
                exp8[2].push_back(w[acc] & ~64'h7);
                acc++;
            end
            @(negedge aclk);
        end
        checks++;
        if (acc !== 5) begin
            errors++; $display("FAIL bp_accepted: got %0d, required 5", acc);
        end
        checks++;
        if (if8.s_tready !== 1'b0) begin
            errors++; $display("FAIL bp_s_tready: got %b, required 0", if8.s_tready);
        end
        checks++;
        if (got8[2].size() !== 0 || if8.m_tvalid !== 8'h04) begin
            errors++; $display("FAIL bp_hold: popped %0d m_tvalid=%h, required 0 and 04", got8[2].size(), if8.m_tvalid);
        end
        mask8 = 8'hFF;
        cyc = 0;
        while (acc < 6 && cyc < 50) begin
            if8.s_tdata = w[acc]; if8.s_tvalid = 1'b1;
            if (if8.s_tready) begin
                @(posedge aclk);
                exp8[2].push_back(w[acc] & ~64'h7);
                acc++;
            end
            @(negedge aclk);
            cyc++;
        end
        if8.s_tvalid = 1'b0;
        wait_idle();
        checks++;
        if (got8[2].size() !== 6) begin
            errors++; $display("FAIL bp_total: got %0d words, required 6", got8[2].size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (got8[2][k] !== exp8[2][k]) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h, required %h", k, got8[2][k], exp8[2][k]);
                end
            end
        end
    endtask

    task automatic test_interleave();
        logic [63:0] d;
        clear_model();
        stab_err = 0;
        rand8 = 1'b1;
        for (int k = 0; k < 64; k++) begin
            d = {$urandom, $urandom};
            d[2:0] = 3'(k % 8);
            if ($urandom_range(0, 3) == 0) @(negedge aclk);
            send(1'b0, d);
        end
        wait_idle();
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (got8[c].size() !== exp8[c].size() || got8[c].size() !== 8) begin
                errors++; $display("FAIL il_count ch%0d: got %0d words, required 8", c, got8[c].size());
            end else begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (got8[c][k] !== exp8[c][k]) begin
                        errors++; $display("FAIL il_word ch%0d[%0d]: got %h, required %h", c, k, got8[c][k], exp8[c][k]);
                    end
                end
            end
        end
        checks++;
        if (stab_err !== 0) begin
            errors++; $display("FAIL il_stability: %0d output changes while stalled, required 0", stab_err);
        end
        checks++;
        if (err8 !== 16'h0) begin
            errors++; $display("FAIL il_err8: got %h, required 0000", err8);
        end
    endtask

    task automatic test_num_ch6();
        logic [63:0] d;
        logic [15:0] want;
        clear_model();
        drop6 = 0;
        for (int k = 0; k < 40; k++) begin
            d = {$urandom, $urandom};
            if (k == 10)      d[2:0] = 3'd6;
            else if (k == 20) d[2:0] = 3'd7;
            else              d[2:0] = 3'($urandom_range(0, 5));
            send(1'b1, d);
        end
        wait_idle();
        checks++;
        if (err6 !== 16'(drop6) || drop6 != 2) begin
            errors++; $display("FAIL ch6_err_cnt: got %0d, required %0d", err6, drop6);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (got6[c].size() !== exp6[c].size()) begin
                errors++; $display("FAIL ch6_count ch%0d: got %0d, required %0d", c, got6[c].size(), exp6[c].size());
            end else begin
                for (int k = 0; k < exp6[c].size(); k++) begin
                    checks++;
                    if (got6[c][k] !== exp6[c][k]) begin
                        errors++; $display("FAIL ch6_word ch%0d[%0d]: got %h, required %h", c, k, got6[c][k], exp6[c][k]);
                    end
                end
            end
        end
        checks++;
        if (err8 !== 16'h0) begin
            errors++; $display("FAIL ch6_err8_untouched: got %h, required 0000", err8);
        end
        // Drive the counter up to one below saturation, then across it
        for (int phase = 0; phase < 3; phase++) begin
            int n;
            n = (phase == 0) ? (65534 - drop6) : 1;
            for (int k = 0; k < n; k++) send(1'b1, 64'h7);
            @(negedge aclk);
            want = (drop6 > 65535) ? 16'hFFFF : 16'(drop6);
            checks++;
            if (err6 !== want) begin
                errors++; $display("FAIL ch6_saturate phase%0d: got %h, required %h", phase, err6, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        mask8 = 8'hF7;
        @(negedge aclk);
        for (int k = 0; k < 3; k++) send(1'b0, ({$urandom, $urandom} & ~64'h7) | 64'h3);
        repeat (3) @(negedge aclk);
        checks++;
        if (if8.m_tvalid !== 8'h08) begin
            errors++; $display("FAIL mid_queued: m_tvalid=%h, required 08", if8.m_tvalid);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (if8.m_tvalid !== 8'h00 || if8.s_tready !== 1'b0) begin
            errors++; $display("FAIL mid_async_clear: m_tvalid=%h s_tready=%b, required 00 and 0", if8.m_tvalid, if8.s_tready);
        end
        @(negedge aclk);
        #2 aresetn = 1'b1;
        #1;
        drop6 = 0;
        checks++;
        if (if8.s_tready !== 1'b1 || err6 !== 16'h0) begin
            errors++; $display("FAIL mid_release: s_tready=%b err6=%h, required 1 and 0000", if8.s_tready, err6);
        end
        @(negedge aclk);
        clear_model();
        mask8 = 8'hFF;
        repeat (20) @(negedge aclk);
        checks++;
        if (got8[3].size() !== 0 || if8.m_tvalid !== 8'h00) begin
            errors++; $display("FAIL mid_stale: %0d words m_tvalid=%h, required 0 and 00", got8[3].size(), if8.m_tvalid);
        end
        send(1'b0, 64'h1234_5678_9ABC_DEF3);
        wait_idle();
        checks++;
        if (got8[3].size() !== 1 || got8[3][0] !== 64'h1234_5678_9ABC_DEF0) begin
            errors++; $display("FAIL mid_after: %0d words, required 1 word 123456789abcdef0", got8[3].size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        if8.s_tdata = '0; if8.s_tvalid = 1'b0;
        if6.s_tdata = '0; if6.s_tvalid = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_interleave();
        test_num_ch6();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
